// File: rtl/id_dispatch_queue_pkg.sv
// Shared ID->ROB dispatch constants and bus types.
// The ROB stage imports the same package so both ends agree on widths.
package id_dispatch_queue_pkg;

  localparam int unsigned ID_PAYLOAD_W      = 160;
  localparam int unsigned DISPATCH_SEQ_W    = 6;
  localparam int unsigned ROB_ENTRIES_TOTAL = 16;
  localparam int unsigned ROB_FREE_W        = 2;
  localparam int unsigned DISPATCH_DEPTH    = 4;

  typedef logic [ID_PAYLOAD_W-1:0]   id_payload_t;
  typedef logic [DISPATCH_SEQ_W-1:0] dispatch_seq_t;
  typedef logic [ROB_FREE_W-1:0]     rob_free_t;

  // A dispatched bundle as the ROB sees it: payload tagged with its sequence number.
  typedef struct packed {
    dispatch_seq_t seq;
    id_payload_t   payload;
  } dispatch_bundle_t;

endpackage

// File: rtl/id_dispatch_queue_if.sv
// Valid/ready handshake between ID, the dispatch queue and the ROB.
// master = the surrounding pipeline, slave = the queue itself.
interface id_dispatch_queue_if
  import id_dispatch_queue_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = ID_PAYLOAD_W,
  parameter int unsigned SEQ_W     = DISPATCH_SEQ_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [SEQ_W-1:0]     out_seq;

  modport master (
    output in_valid,
    output in_payload,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_payload,
    input  out_seq
  );

  modport slave (
    input  in_valid,
    input  in_payload,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_payload,
    output out_seq
  );

endinterface

// File: rtl/id_dispatch_queue_credit.sv
// ROB-entry credit counter: decrements on dispatch, increments on retire,
// reloads on flush, saturates at MAX_CREDITS with a sticky overflow flag.
module dispatch_credit_counter
  import id_dispatch_queue_pkg::*;
#(
  parameter int unsigned MAX_CREDITS = ROB_ENTRIES_TOTAL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dec,
  input  rob_free_t                    inc,
  output logic [$clog2(MAX_CREDITS):0] credits,
  output logic                         credit_err
);

  localparam int unsigned CREDIT_W = $clog2(MAX_CREDITS) + 1;
  localparam int unsigned SUM_W    = CREDIT_W + 1;

  logic [SUM_W-1:0] sum_c;
  logic             over_c;

  // dec is only ever asserted with credits != 0, so the sum cannot go negative.
  assign sum_c  = SUM_W'(credits) + SUM_W'(inc) - SUM_W'(dec);
  assign over_c = (sum_c > SUM_W'(MAX_CREDITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CREDIT_W'(MAX_CREDITS);
      credit_err <= 1'b0;
    end else if (flush) begin
      credits    <= CREDIT_W'(MAX_CREDITS);
    end else if (over_c) begin
      credits    <= CREDIT_W'(MAX_CREDITS);
      credit_err <= 1'b1;
    end else begin
      credits    <= CREDIT_W'(sum_c);
    end
  end

endmodule

// File: rtl/id_dispatch_queue.sv
// ID->ROB decoupling FIFO that releases bundles only against ROB credits
// and tags each released bundle with a wrapping dispatch sequence number.
module id_dispatch_queue
  import id_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = DISPATCH_DEPTH,
  parameter int unsigned PAYLOAD_W   = ID_PAYLOAD_W,
  parameter int unsigned ROB_ENTRIES = ROB_ENTRIES_TOTAL,
  parameter int unsigned SEQ_W       = DISPATCH_SEQ_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  id_dispatch_queue_if.slave            bus,
  input  rob_free_t                     rob_free_cnt,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(ROB_ENTRIES):0]  credits,
  output logic                          credit_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [SEQ_W-1:0]     seq;
  logic                 enq_c;
  logic                 deq_c;

  // Handshake flags come only from registered state; no path from out_ready to in_ready.
  assign bus.in_ready  = (count != CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0) && (credits != '0);

  // A flush cycle discards both handshakes, even if they looked accepted.
  assign enq_c = bus.in_valid && bus.in_ready && !flush;
  assign deq_c = bus.out_valid && bus.out_ready && !flush;

  assign bus.out_payload = (count != '0) ? mem[head] : '0;
  assign bus.out_seq     = seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      seq   <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_c) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq_c) begin
        head <= head + PTR_W'(1);
        seq  <= seq + SEQ_W'(1);
      end
      if (enq_c && !deq_c) begin
        count <= count + CNT_W'(1);
      end else if (deq_c && !enq_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      mem[tail] <= bus.in_payload;
    end
  end

  dispatch_credit_counter #(
    .MAX_CREDITS (ROB_ENTRIES)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .dec        (deq_c),
    .inc        (rob_free_cnt),
    .credits    (credits),
    .credit_err (credit_err)
  );

endmodule

// File: tb/tb_id_dispatch_queue.sv
// Directed bench for id_dispatch_queue: fill/drain, credit starvation,
// wrap under concurrent traffic, flush and credit overflow.
`timescale 1ns/1ps
module tb_id_dispatch_queue;
  import id_dispatch_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush;
  logic [1:0] rob_free_cnt;
  logic [2:0] count;
  logic [4:0] credits;
  logic       credit_err;
  int         total = 0;
  int         bad = 0;

  id_dispatch_queue_if bus ();

  id_dispatch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .rob_free_cnt (rob_free_cnt),
    .count        (count),
    .credits      (credits),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  a_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.in_valid && !bus.in_ready) |=> (!bus.in_valid || $stable(bus.in_payload)));
  a_count: assert property (@(posedge clk) disable iff (rst) count <= 3'd4);
  a_credit: assert property (@(posedge clk) disable iff (rst) !(bus.out_valid && credits == 5'd0));

  function automatic logic [159:0] pl(input int k);
    pl = {5{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    rob_free_cnt  = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.in_payload = '0;
    step();
    step();
    rst = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL reset_credits got=%0d exp=16", credits); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", credit_err); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_payload !== 160'd0) begin bad++; $display("FAIL reset_payload got=%h exp=0", bus.out_payload); end
    total++; if (bus.out_seq !== 6'd0) begin bad++; $display("FAIL reset_seq got=%0d exp=0", bus.out_seq); end
  endtask

  // A,B,C,D = pl(0..3) fill the queue; E = pl(4) is held off while full.
  task automatic test_fill();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_payload = pl(k);
      step();
    end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fill_count3 got=%0d exp=3", count); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fill_out_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_payload !== pl(0)) begin bad++; $display("FAIL fill_head got=%h exp=%h", bus.out_payload, pl(0)); end
    total++; if (bus.out_seq !== 6'd0) begin bad++; $display("FAIL fill_seq got=%0d exp=0", bus.out_seq); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL fill_credits got=%0d exp=16", credits); end
    bus.in_payload = pl(3);
    step();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count4 got=%0d exp=4", count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", bus.in_ready); end
    bus.in_payload = pl(4);
    step();
    step();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_held_count got=%0d exp=4", count); end
    total++; if (bus.out_payload !== pl(0)) begin bad++; $display("FAIL fill_held_head got=%h exp=%h", bus.out_payload, pl(0)); end
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_payload !== pl(i)) begin bad++; $display("FAIL drain_payload%0d got=%h exp=%h", i, bus.out_payload, pl(i)); end
      total++; if (bus.out_seq !== 6'(i)) begin bad++; $display("FAIL drain_seq%0d got=%0d exp=%0d", i, bus.out_seq, i); end
      step();
      if (i == 0) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_back got=%b exp=1", bus.in_ready); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL drain_count_first got=%0d exp=3", count); end
      end
      if (i == 1) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL drain_count got=%0d exp=1", count); end
    total++; if (credits !== 5'd12) begin bad++; $display("FAIL drain_credits got=%0d exp=12", credits); end
    total++; if (bus.out_payload !== pl(4)) begin bad++; $display("FAIL drain_e_head got=%h exp=%h", bus.out_payload, pl(4)); end
    total++; if (bus.out_seq !== 6'd4) begin bad++; $display("FAIL drain_e_seq got=%0d exp=4", bus.out_seq); end
  endtask

  task automatic test_starve();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL starve_flush_count got=%0d exp=0", count); end
    total++; if (out_seq_now() !== 6'd4) begin bad++; $display("FAIL starve_flush_seq got=%0d exp=4", bus.out_seq); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_payload = pl(100 + k);
      if (k >= 1) begin
        total++; if (bus.out_payload !== pl(100 + k - 1)) begin bad++; $display("FAIL starve_order%0d got=%h exp=%h", k, bus.out_payload, pl(100 + k - 1)); end
      end
      step();
    end
    total++; if (credits !== 5'd0) begin bad++; $display("FAIL starve_credits got=%0d exp=0", credits); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL starve_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL starve_count1 got=%0d exp=1", count); end
    bus.in_payload = pl(117);
    step();
    bus.in_valid = 1'b0;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL starve_count2 got=%0d exp=2", count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL starve_blocked got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_seq !== 6'd20) begin bad++; $display("FAIL starve_seq got=%0d exp=20", bus.out_seq); end
    rob_free_cnt = 2'd2;
    step();
    rob_free_cnt = 2'd0;
    total++; if (credits !== 5'd2) begin bad++; $display("FAIL starve_pulse_credits got=%0d exp=2", credits); end
    total++; if (bus.out_payload !== pl(116)) begin bad++; $display("FAIL starve_pulse_head got=%h exp=%h", bus.out_payload, pl(116)); end
    step();
    step();
    total++; if (credits !== 5'd0) begin bad++; $display("FAIL starve_after_credits got=%0d exp=0", credits); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL starve_after_count got=%0d exp=0", count); end
    total++; if (bus.out_seq !== 6'd22) begin bad++; $display("FAIL starve_after_seq got=%0d exp=22", bus.out_seq); end
    // Dispatch at credits=1 with one retire in the same cycle.
    bus.out_ready  = 1'b0;
    rob_free_cnt   = 2'd1;
    bus.in_valid   = 1'b1;
    bus.in_payload = pl(200);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (credits !== 5'd1) begin bad++; $display("FAIL one_pre_credits got=%0d exp=1", credits); end
    step();
    rob_free_cnt  = 2'd0;
    bus.out_ready = 1'b0;
    total++; if (credits !== 5'd1) begin bad++; $display("FAIL one_credits got=%0d exp=1", credits); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL one_count got=%0d exp=0", count); end
    total++; if (bus.out_seq !== 6'd23) begin bad++; $display("FAIL one_seq got=%0d exp=23", bus.out_seq); end
  endtask

  function automatic logic [5:0] out_seq_now();
    out_seq_now = bus.out_seq;
  endfunction

  task automatic test_wrap();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_payload = pl(300);
    step();
    rob_free_cnt = 2'd1;
    for (int j = 1; j < 38; j++) begin
      bus.in_payload = pl(300 + j);
      step();
    end
    bus.out_ready  = 1'b0;
    rob_free_cnt   = 2'd0;
    bus.in_payload = pl(338);
    step();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_pre_count got=%0d exp=2", count); end
    total++; if (bus.out_seq !== 6'd60) begin bad++; $display("FAIL wrap_pre_seq got=%0d exp=60", bus.out_seq); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL wrap_pre_credits got=%0d exp=16", credits); end
    bus.out_ready = 1'b1;
    rob_free_cnt  = 2'd1;
    for (int i = 0; i < 10; i++) begin
      bus.in_payload = pl(339 + i);
      total++; if (bus.out_payload !== pl(337 + i)) begin bad++; $display("FAIL wrap_order%0d got=%h exp=%h", i, bus.out_payload, pl(337 + i)); end
      total++; if (bus.out_seq !== 6'((60 + i) % 64)) begin bad++; $display("FAIL wrap_seq%0d got=%0d exp=%0d", i, bus.out_seq, (60 + i) % 64); end
      step();
      total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=2", i, count); end
    end
    idle();
    total++; if (bus.out_seq !== 6'd6) begin bad++; $display("FAIL wrap_seq_end got=%0d exp=6", bus.out_seq); end
    total++; if (bus.out_payload !== pl(347)) begin bad++; $display("FAIL wrap_head_end got=%h exp=%h", bus.out_payload, pl(347)); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL wrap_credits got=%0d exp=16", credits); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    for (int j = 0; j < 12; j++) begin
      bus.in_payload = pl(400 + j);
      step();
    end
    bus.out_ready = 1'b0;
    bus.in_payload = pl(412);
    step();
    bus.in_payload = pl(413);
    step();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    total++; if (credits !== 5'd5) begin bad++; $display("FAIL flush_pre_credits got=%0d exp=5", credits); end
    flush          = 1'b1;
    bus.in_payload = pl(499);
    bus.out_ready  = 1'b1;
    rob_free_cnt   = 2'd2;
    step();
    idle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL flush_credits got=%0d exp=16", credits); end
    total++; if (bus.out_seq !== 6'd17) begin bad++; $display("FAIL flush_seq got=%0d exp=17", bus.out_seq); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", credit_err); end
    total++; if (bus.out_payload !== 160'd0) begin bad++; $display("FAIL flush_payload got=%h exp=0", bus.out_payload); end
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_not_stored got=%0d exp=0", count); end
    bus.in_valid   = 1'b1;
    bus.in_payload = pl(450);
    step();
    bus.in_valid = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_new_count got=%0d exp=1", count); end
    total++; if (bus.out_payload !== pl(450)) begin bad++; $display("FAIL flush_new_head got=%h exp=%h", bus.out_payload, pl(450)); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (credits !== 5'd15) begin bad++; $display("FAIL ovf_pre_credits got=%0d exp=15", credits); end
    rob_free_cnt = 2'd2;
    step();
    rob_free_cnt = 2'd0;
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL ovf_credits got=%0d exp=16", credits); end
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", credit_err); end
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", credit_err); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL ovf_flush_credits got=%0d exp=16", credits); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL ovf_rst_err got=%b exp=0", credit_err); end
    total++; if (bus.out_seq !== 6'd0) begin bad++; $display("FAIL ovf_rst_seq got=%0d exp=0", bus.out_seq); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL ovf_rst_count got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_starve();
    test_wrap();
    test_flush();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
